alu_nibble_seq: RTL

- Multi-cycle sequencer that runs WIDTH-bit ALU operations through one internal alu4 instance, one nibble per cycle, least-significant nibble first.
- Chains the carry between nibbles through a register, assembles the full result, and produces status flags.
- Sits directly upstream of alu4: it drives alu4's A/B/cIn/ctrl and consumes its aluOut/cOut.
- The datapath and register stage use it wherever a wide ALU is not affordable.

---
 rtl/alu_nibble_seq.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/alu_nibble_seq.sv
// Wide ALU built from one 4-bit slice, one nibble per cycle LSB first; flags valid with done.
// Latency: done NIB+1 edges after the accepting edge (counting it); start is ignored while busy (no queueing).

module alu4 (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       cIn,
    input  logic [2:0] ctrl,
    output logic [3:0] aluOut,
    output logic       cOut
);
    logic [4:0] sum;

    always_comb begin
        sum    = '0;
        aluOut = '0;
        cOut   = 1'b0;
        case (ctrl)
            3'b000: aluOut = B;
            3'b010: begin
                sum    = {1'b0, A} + {1'b0, B} + {4'b0, cIn};
                aluOut = sum[3:0];
                cOut   = sum[4];
            end
            3'b011: begin
                // Subtract as A + ~B + cIn; the first nibble gets cIn=1
                sum    = {1'b0, A} + {1'b0, ~B} + {4'b0, cIn};
                aluOut = sum[3:0];
                cOut   = sum[4];
            end
            3'b100:  aluOut = A & B;
            3'b101:  aluOut = A | B;
            3'b110:  aluOut = A ^ B;
            default: aluOut = '0;
        endcase
    end
endmodule

module alu_nibble_seq #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ctrl,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carryOut,
    output logic             overflow
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = $clog2(NIB);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       ctrl_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;

    logic             legal, accept, last, arith;
    logic [3:0]       nib_a, nib_b, alu_out;
    logic             alu_cout;
    logic [WIDTH-1:0] full_res;
    logic             ovf_nxt;

    assign legal = (ctrl == 3'b000) || (ctrl == 3'b010) || (ctrl == 3'b011) ||
                   (ctrl == 3'b100) || (ctrl == 3'b101) || (ctrl == 3'b110);

    assign nib_a = a_q[{cnt_q, 2'b00} +: 4];
    assign nib_b = b_q[{cnt_q, 2'b00} +: 4];

    alu4 u_alu4 (
        .A      (nib_a),
        .B      (nib_b),
        .cIn    (carry_q),
        .ctrl   (ctrl_q),
        .aluOut (alu_out),
        .cOut   (alu_cout)
    );

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (start && legal) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt_q == CW'(NIB - 1)) begin
                    last      = 1'b1;
                    state_nxt = FIN;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The top nibble is produced last, so splice it in to see the final result a cycle early
    assign full_res = {alu_out, result[WIDTH-5:0]};
    assign arith    = (ctrl_q[2:1] == 2'b01);

    always_comb begin
        ovf_nxt = 1'b0;
        if (ctrl_q == 3'b010)
            ovf_nxt = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (full_res[WIDTH-1] != a_q[WIDTH-1]);
        else if (ctrl_q == 3'b011)
            ovf_nxt = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (full_res[WIDTH-1] != a_q[WIDTH-1]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            ctrl_q   <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            err      <= 1'b0;
            result   <= '0;
            zero     <= 1'b0;
            negative <= 1'b0;
            carryOut <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= (state == IDLE) && start && !legal;
            if (accept) begin
                a_q     <= A;
                b_q     <= B;
                ctrl_q  <= ctrl;
                carry_q <= ctrl[0];
                cnt_q   <= '0;
            end
            if (state == RUN) begin
                result[{cnt_q, 2'b00} +: 4] <= alu_out;
                carry_q                     <= alu_cout;
                cnt_q                       <= cnt_q + CW'(1);
            end
            if (last) begin
                zero     <= ~|full_res;
                negative <= full_res[WIDTH-1];
                carryOut <= arith & alu_cout;
                overflow <= ovf_nxt;
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == FIN);
endmodule
